// File: rtl/context_switch_controller.sv
// -----------------------------------------------------------------------------
// context_switch_controller
//
// Round-robin process scheduler for the stack core. A FIFO ready queue holds
// process base addresses. On yield the running context is written to RAM at
// base+0 ({SP, CSP-2}) and base+1 ({flags, 3'b0, PC}); the next process is then
// dequeued and the external resume-state unit reloads it from the same words.
// The controller owns the RAM port in SAVE/SWITCH/RESUME; the core owns it in RUN.
//
// Optional feature macro: PREEMPT_EN
//   defined   -> a slice counter forces the yield path after TIMESLICE RUN cycles
//   undefined -> switches happen only on yield/halt
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   spawn, spawnBase    enqueue request and base address (held until accepted)
//   spawnAccepted       1-cycle pulse, the cycle after the entry was enqueued
//   yield, halt         core switch / retire requests (RUN only, halt wins)
//   coreSp, coreCsp,
//   corePc, coreFlags   live context of the running process
//   coreAddress,
//   coreRwMode,
//   coreDataIn          core side of the RAM mux
//   ramAddress,
//   ramRwMode,
//   ramDataIn           RAM port
//   resumeAddress       resume unit word offset (0/1) relative to base
//   resumeReset         active-low reset to the resume unit
//   resumeFinished      resume unit done
//   coreStall           high whenever the core does not own the machine
//   running             a process is loaded
//   currentBase         base of the loaded process
//   queueCount          ready-queue occupancy
// -----------------------------------------------------------------------------
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module context_switch_controller #(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int TIMESLICE   = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spawn,
    input  logic [ADDR_BITS-1:0]         spawnBase,
    output logic                         spawnAccepted,
    input  logic                         yield,
    input  logic                         halt,
    input  logic [ADDR_BITS-1:0]         coreSp,
    input  logic [ADDR_BITS-1:0]         coreCsp,
    input  logic [8:0]                   corePc,
    input  logic [3:0]                   coreFlags,
    input  logic [ADDR_BITS-1:0]         coreAddress,
    input  logic                         coreRwMode,
    input  logic [DATA_BITS-1:0]         coreDataIn,
    output logic [ADDR_BITS-1:0]         ramAddress,
    output logic                         ramRwMode,
    output logic [DATA_BITS-1:0]         ramDataIn,
    input  logic [ADDR_BITS-1:0]         resumeAddress,
    output logic                         resumeReset,
    input  logic                         resumeFinished,
    output logic                         coreStall,
    output logic                         running,
    output logic [ADDR_BITS-1:0]         currentBase,
    output logic [$clog2(QUEUE_DEPTH):0] queueCount
);

    localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        IDLE, RUN, SAVE0, SAVE1, SWITCH, RESUME
    } state_t;

    state_t state, state_next;

    logic                 ram_cycle;   // second cycle of a 2-cycle RAM word
    logic                 yield_path;  // SWITCH was reached through SAVE1
    logic [DATA_BITS-1:0] save_q;      // word sampled in first SAVE cycle
    logic [DATA_BITS-1:0] word0, word1;

    logic [ADDR_BITS-1:0] queue [QUEUE_DEPTH];
    logic [PTR_BITS-1:0]  head, tail;
    logic [CNT_BITS-1:0]  count;

    logic                 queue_nonempty, switch_op, spawn_ok;
    logic                 push, pop;
    logic [ADDR_BITS-1:0] push_data;
    logic                 preempt_hit;

    // CSP is stored pre-decremented; the resume unit adds the 2 back.
    assign word0 = DATA_BITS'({coreSp, coreCsp - ADDR_BITS'(2)});
    assign word1 = DATA_BITS'({coreFlags, 3'b000, corePc});

    assign queue_nonempty = (count != '0);
    assign switch_op      = (state == SWITCH) && queue_nonempty;
    assign spawn_ok       = spawn && !switch_op && (count < FULL);

    // On the yield path push and pop share the SWITCH cycle, so a full queue
    // rotates without ever exceeding its depth.
    assign pop       = switch_op;
    assign push      = spawn_ok || (switch_op && yield_path);
    assign push_data = switch_op ? currentBase : spawnBase;

`ifdef PREEMPT_EN
    localparam int SLICE_BITS = $clog2(TIMESLICE) + 1;
    logic [SLICE_BITS-1:0] slice;

    always_ff @(posedge clk) begin
        if (!reset || state != RUN) slice <= '0;
        else                        slice <= slice + 1'b1;
    end

    assign preempt_hit = (state == RUN) && (slice == SLICE_BITS'(TIMESLICE - 1));
`else
    assign preempt_hit = 1'b0 & (TIMESLICE != 0);
`endif

    always_comb begin
        state_next  = state;
        ramAddress  = currentBase;
        ramRwMode   = `RAM_READ;
        ramDataIn   = '0;
        resumeReset = 1'b0;
        case (state)
            IDLE: begin
                if (queue_nonempty) state_next = SWITCH;
            end
            RUN: begin
                ramAddress = coreAddress;
                ramRwMode  = coreRwMode;
                ramDataIn  = coreDataIn;
                if (halt)                      state_next = SWITCH;
                else if (yield || preempt_hit) state_next = SAVE0;
            end
            SAVE0: begin
                ramRwMode = `RAM_WRITE;
                ramDataIn = ram_cycle ? save_q : word0;
                if (ram_cycle) state_next = SAVE1;
            end
            SAVE1: begin
                ramAddress = currentBase + ADDR_BITS'(1);
                ramRwMode  = `RAM_WRITE;
                ramDataIn  = ram_cycle ? save_q : word1;
                if (ram_cycle) state_next = SWITCH;
            end
            SWITCH: begin
                // Empty queue on the yield path re-selects the yielding process.
                if (!queue_nonempty && !yield_path) state_next = IDLE;
                else                                state_next = RESUME;
            end
            RESUME: begin
                resumeReset = 1'b1;
                ramAddress  = currentBase + resumeAddress;
                if (resumeFinished) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            ram_cycle     <= 1'b0;
            yield_path    <= 1'b0;
            save_q        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            currentBase   <= '0;
            running       <= 1'b0;
            spawnAccepted <= 1'b0;
        end else begin
            state         <= state_next;
            ram_cycle     <= (state == SAVE0 || state == SAVE1) ? ~ram_cycle : 1'b0;
            yield_path    <= (state == SAVE1);
            spawnAccepted <= spawn_ok;

            if ((state == SAVE0 || state == SAVE1) && !ram_cycle)
                save_q <= (state == SAVE0) ? word0 : word1;

            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head        <= head + 1'b1;
                currentBase <= queue[head];
            end
            count <= count + CNT_BITS'(push) - CNT_BITS'(pop);

            if (state == RESUME && resumeFinished)
                running <= 1'b1;
            else if (state == SWITCH && !queue_nonempty && !yield_path)
                running <= 1'b0;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) queue[tail] <= push_data;
    end

    assign coreStall  = (state != RUN);
    assign queueCount = count;

endmodule

// File: tb/tb_context_switch_controller.sv
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module tb_context_switch_controller;
    localparam int QD = 4;
    localparam int TS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, spawn, spawnAccepted, yield, halt;
    logic [7:0]  spawnBase, coreSp, coreCsp, coreAddress, ramAddress;
    logic [8:0]  corePc;
    logic [3:0]  coreFlags;
    logic        coreRwMode, ramRwMode;
    logic [15:0] coreDataIn, ramDataIn;
    logic [7:0]  resumeAddress, currentBase;
    logic        resumeReset, resumeFinished, coreStall, running;
    logic [2:0]  queueCount;

    context_switch_controller #(.TIMESLICE(TS)) dut (
        .clk(clk), .reset(reset), .spawn(spawn), .spawnBase(spawnBase),
        .spawnAccepted(spawnAccepted), .yield(yield), .halt(halt),
        .coreSp(coreSp), .coreCsp(coreCsp), .corePc(corePc), .coreFlags(coreFlags),
        .coreAddress(coreAddress), .coreRwMode(coreRwMode), .coreDataIn(coreDataIn),
        .ramAddress(ramAddress), .ramRwMode(ramRwMode), .ramDataIn(ramDataIn),
        .resumeAddress(resumeAddress), .resumeReset(resumeReset),
        .resumeFinished(resumeFinished), .coreStall(coreStall), .running(running),
        .currentBase(currentBase), .queueCount(queueCount)
    );

    // Resume-state unit stand-in: reads base+0 for 2 cycles, base+1 for 2,
    // finished in its 4th cycle out of reset.
    logic [2:0] rcnt = '0;
    always @(posedge clk) begin
        if (!resumeReset)     rcnt <= '0;
        else if (rcnt != 3'd7) rcnt <= rcnt + 3'd1;
    end
    assign resumeAddress  = (rcnt >= 3'd2) ? 8'd1 : 8'd0;
    assign resumeFinished = (rcnt == 3'd3);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM write log seen on the port.
    logic [15:0] wmem [256];
    int          wcount = 0;
    always @(negedge clk) begin
        if (ramRwMode === `RAM_WRITE) begin
            wmem[ramAddress] = ramDataIn;
            wcount++;
        end
    end

    // ---------------- behavioural model ----------------
    // m_op: 0 = no switch in progress (RUN if m_inrun, else IDLE)
    //       1 = yield sequence: 4 save cycles, switch, 4 resume cycles
    //       2 = switch-only sequence (halt or idle start): switch, 4 resume cycles
    int          m_op = 0, m_seq = 0, m_slice = 0;
    bit          m_inrun = 0, m_running = 0, m_acc = 0;
    logic [7:0]  m_base = '0;
    logic [7:0]  m_q [$];
    logic [15:0] m_cap = '0;

    function automatic int sw_seq();
        return (m_op == 1) ? 5 : 1;
    endfunction
    function automatic bit m_run();
        return (m_op == 0) && m_inrun;
    endfunction
    function automatic logic [15:0] w0();
        return {coreSp, coreCsp - 8'd2};
    endfunction
    function automatic logic [15:0] w1();
        return {coreFlags, 3'b000, corePc};
    endfunction

    always @(posedge clk) begin
        int sw;
        bit swop, acc, hit;
        if (!reset) begin
            m_op = 0; m_seq = 0; m_inrun = 0; m_running = 0; m_base = '0;
            m_q.delete(); m_acc = 0; m_slice = 0;
        end else begin
            sw   = sw_seq();
            swop = (m_op != 0) && (m_seq == sw) && (m_q.size() > 0);
            acc  = spawn && !swop && (m_q.size() < QD);
            if (m_op == 0) begin
                if (!m_inrun) begin
                    if (m_q.size() > 0) begin m_op = 2; m_seq = 1; end
                end else begin
                    hit = 0;
`ifdef PREEMPT_EN
                    hit = (m_slice == TS - 1);
`endif
                    if (halt) begin m_inrun = 0; m_op = 2; m_seq = 1; end
                    else if (yield || hit) begin m_inrun = 0; m_op = 1; m_seq = 1; end
                    else m_slice++;
                end
            end else if (m_seq == sw) begin
                if (m_q.size() > 0) begin
                    if (m_op == 1) m_q.push_back(m_base);
                    m_base = m_q.pop_front();
                    m_seq++;
                end else if (m_op == 1) m_seq++;
                else begin m_op = 0; m_running = 0; end
            end else if (m_seq == sw + 4) begin
                m_op = 0; m_inrun = 1; m_running = 1; m_slice = 0;
            end else begin
                if (m_op == 1 && m_seq == 1) m_cap = w0();
                if (m_op == 1 && m_seq == 3) m_cap = w1();
                m_seq++;
            end
            if (acc) m_q.push_back(spawnBase);
            m_acc = acc;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk) begin
        int k;
        if (chk_en) begin
            check("coreStall", coreStall, !m_run());
            check("running", running, m_running);
            check("currentBase", currentBase, m_base);
            check("queueCount", queueCount, m_q.size());
            check("spawnAccepted", spawnAccepted, m_acc);
            check("resumeReset", resumeReset, (m_op != 0) && (m_seq > sw_seq()));
            if (m_run()) begin
                check("ramRwMode run", ramRwMode, coreRwMode);
                check("ramAddress run", ramAddress, coreAddress);
                check("ramDataIn run", ramDataIn, coreDataIn);
            end else if (m_op == 1 && m_seq <= 4) begin
                check("ramRwMode save", ramRwMode, `RAM_WRITE);
                check("ramAddress save", ramAddress, m_base + ((m_seq >= 3) ? 8'd1 : 8'd0));
                check("ramDataIn save", ramDataIn,
                      (m_seq == 1) ? w0() : (m_seq == 3) ? w1() : m_cap);
            end else begin
                check("ramRwMode rd", ramRwMode, `RAM_READ);
                if (m_op != 0 && m_seq > sw_seq()) begin
                    k = m_seq - sw_seq() - 1;
                    check("ramAddress resume", ramAddress, m_base + ((k >= 2) ? 8'd1 : 8'd0));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_run(input int max);
        int i;
        for (i = 0; i < max && !m_run(); i++) cyc(1);
        if (!m_run()) check("wait_run timeout", 0, 1);
    endtask

    task automatic do_spawn(input logic [7:0] b);
        spawn = 1; spawnBase = b;
        cyc(1);
        spawn = 0;
    endtask

    task automatic do_reset();
        reset = 0; spawn = 0; yield = 0; halt = 0;
        cyc(2);
        reset = 1;
    endtask

    initial begin
        int n, w0cnt;
        bit seen;
        reset = 0; spawn = 0; yield = 0; halt = 0; spawnBase = '0;
        coreSp = '0; coreCsp = '0; corePc = '0; coreFlags = '0;
        coreAddress = '0; coreRwMode = `RAM_READ; coreDataIn = '0;
        @(posedge clk); #1;
        chk_en = 1;
        cyc(2);
        check("rst queueCount", queueCount, 0);
        check("rst running", running, 0);
        check("rst coreStall", coreStall, 1);
        check("rst resumeReset", resumeReset, 0);
        check("rst currentBase", currentBase, 0);
        check("rst ramRwMode", ramRwMode, `RAM_READ);
        check("rst spawnAccepted", spawnAccepted, 0);
        reset = 1;

        // first process
        do_spawn(8'h40);
        check("t1 spawnAccepted", spawnAccepted, 1);
        check("t1 queueCount", queueCount, 1);
        wait_run(20);
        check("t1 currentBase", currentBase, 8'h40);

        // yield with a known context, queue {0x80}
        do_spawn(8'h80);
        coreSp = 8'h30; coreCsp = 8'h12; corePc = 9'h1A5; coreFlags = 4'hA;
        yield = 1;
        cyc(1);
        yield = 0;
        n = 1;
        while (coreStall && n < 30) begin cyc(1); n++; end
        check("t2 yield->RUN cycles", n, 10);
        check("t2 word base+0", wmem[8'h40], 16'h3010);
        check("t2 word base+1", wmem[8'h41], 16'hA1A5);
        check("t2 currentBase", currentBase, 8'h80);

        // full queue rotation with a blocked spawn
        do_spawn(8'h11); do_spawn(8'h22); do_spawn(8'h33);
        check("t3 full count", queueCount, 4);
        spawn = 1; spawnBase = 8'h44; yield = 1;
        cyc(1);
        yield = 0;
        wait_run(30);
        check("t3 count after rotate", queueCount, 4);
        check("t3 rotate base", currentBase, 8'h40);
        check("t3 spawn blocked", spawnAccepted, 0);
        halt = 1;
        cyc(1);
        halt = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (spawnAccepted) seen = 1; else cyc(1);
        end
        spawn = 0;
        check("t3 spawn after pop", seen, 1);
        wait_run(30);
        check("t3 halt pop base", currentBase, 8'h11);
        check("t3 count refill", queueCount, 4);

        // halt with empty queue
        do_reset();
        do_spawn(8'h40);
        wait_run(20);
        w0cnt = wcount;
        halt = 1;
        cyc(1);
        halt = 0;
        cyc(2);
        check("t4 running", running, 0);
        check("t4 no writes", wcount, w0cnt);
        check("t4 stall", coreStall, 1);
        do_spawn(8'h60);
        wait_run(20);
        check("t4 currentBase", currentBase, 8'h60);

        // reset during SAVE1
        do_spawn(8'h70);
        yield = 1;
        cyc(1);
        yield = 0;
        cyc(2);
        check("t5 in SAVE1 write", ramRwMode, `RAM_WRITE);
        reset = 0;
        cyc(1);
        reset = 1;
        check("t5 ramRwMode", ramRwMode, `RAM_READ);
        check("t5 queueCount", queueCount, 0);
        check("t5 coreStall", coreStall, 1);

        // time slice
        do_spawn(8'h40);
        wait_run(20);
        n = 0;
        while (!coreStall && n < 40) begin cyc(1); n++; end
`ifdef PREEMPT_EN
        check("t6 preempt cycles", n, TS);
        check("t6 preempt save", ramRwMode, `RAM_WRITE);
`else
        check("t6 no preempt", n, 40);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 299) != 0);
            spawn       = ($urandom_range(0, 3) == 0);
            spawnBase   = 8'($urandom);
            yield       = ($urandom_range(0, 7) == 0);
            halt        = ($urandom_range(0, 15) == 0);
            coreSp      = 8'($urandom);
            coreCsp     = 8'($urandom);
            corePc      = 9'($urandom);
            coreFlags   = 4'($urandom);
            coreAddress = 8'($urandom);
            coreRwMode  = 1'($urandom);
            coreDataIn  = 16'($urandom);
            cyc(1);
        end
        reset = 1; spawn = 0; yield = 0; halt = 0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
